// File: rtl/pinmux_pkg.sv
// Shared types and constants for the pinmux configuration loader and the
// tools that build its pin-configuration tables.
package pinmux_pkg;

    localparam logic [31:0] PINMUX_BASE_ADDR       = 32'h0400_0000;
    localparam int unsigned PINMUX_PAD_NUM         = 32;
    localparam logic [15:0] PINMUX_PAD_CFG0_OFFSET = 16'h0000;
    localparam logic [15:0] PINMUX_PAD_STRIDE      = 16'h0004;
    localparam logic [15:0] PINMUX_CTRL_OFFSET     = 16'h0100;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_SCAN   = 3'd1,
        LDR_WR_REQ = 3'd2,
        LDR_WR_RSP = 3'd3,
        LDR_RD_REQ = 3'd4,
        LDR_RD_RSP = 3'd5,
        LDR_DONE   = 3'd6,
        LDR_ERR    = 3'd7
    } pinmux_ldr_state_e;

    // Register offset of the per-pad configuration word for a given pad.
    function automatic logic [15:0] pinmux_pad_offset(input int unsigned pad);
        return PINMUX_PAD_CFG0_OFFSET + 16'(pad) * PINMUX_PAD_STRIDE;
    endfunction

endpackage

// File: rtl/pinmux_cfg_timer.sv
// Saturating wait-cycle counter; expired_c flags the TIMEOUT-th cycle spent
// enabled since the last clear. TIMEOUT of 0 never expires.
module pinmux_cfg_timer
    import pinmux_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CW'(LIM))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_c = (TIMEOUT != 0) && en_i && (cnt_q == CW'(LIM));

endmodule

// File: rtl/pinmux_cfg_loader.sv
// OBI master that writes an enabled-entry pin-configuration table into the
// pinmux register block, optionally reading each entry back to verify it.
module pinmux_cfg_loader
    import pinmux_pkg::*;
#(
    parameter int unsigned ENTRY_NUM  = 8,
    parameter logic [31:0] BASE_ADDR  = PINMUX_BASE_ADDR,
    parameter int unsigned TIMEOUT    = 64,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       verify_en_i,
    input  logic [ENTRY_NUM-1:0]       cfg_vld_i,
    input  logic [ENTRY_NUM-1:0][15:0] cfg_addr_i,
    input  logic [ENTRY_NUM-1:0][31:0] cfg_data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [$clog2(ENTRY_NUM):0] err_idx_o,
    output logic                       req_o,
    output logic                       we_o,
    output logic [3:0]                 be_o,
    output logic [31:0]                addr_o,
    output logic [31:0]                data_o,
    input  logic                       gnt_i,
    input  logic                       rvalid_i,
    input  logic [31:0]                data_i
);

    localparam int unsigned IW = $clog2(ENTRY_NUM) + 1;
    localparam int unsigned SW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    pinmux_ldr_state_e state_q;
    logic [IW-1:0]     idx_q;
    logic              verify_q;
    logic              auto_q;

    logic [SW-1:0]     sel_c;
    logic              cur_vld_c;
    logic [31:0]       cur_addr_c;
    logic [31:0]       cur_data_c;
    logic              last_c;
    logic              in_wait_c;
    logic              step_c;
    logic              tmo_c;

    // Current table entry; idx == ENTRY_NUM is caught by last_c before use.
    assign sel_c      = SW'(idx_q);
    assign cur_vld_c  = cfg_vld_i[sel_c];
    assign cur_addr_c = {BASE_ADDR[31:16], cfg_addr_i[sel_c]};
    assign cur_data_c = cfg_data_i[sel_c];
    assign last_c     = (idx_q == IW'(ENTRY_NUM));

    assign in_wait_c = (state_q == LDR_WR_REQ) || (state_q == LDR_WR_RSP) ||
                       (state_q == LDR_RD_REQ) || (state_q == LDR_RD_RSP);
    assign step_c    = (((state_q == LDR_WR_REQ) || (state_q == LDR_RD_REQ)) && gnt_i) ||
                       (((state_q == LDR_WR_RSP) || (state_q == LDR_RD_RSP)) && rvalid_i);

    // Timer restarts on every state change into or between the wait states.
    pinmux_cfg_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (!in_wait_c || step_c),
        .en_i      (in_wait_c),
        .expired_c (tmo_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LDR_IDLE;
            idx_q     <= '0;
            verify_q  <= 1'b0;
            auto_q    <= AUTO_START;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            err_idx_o <= '0;
            req_o     <= 1'b0;
            we_o      <= 1'b0;
            be_o      <= 4'h0;
            addr_o    <= '0;
            data_o    <= '0;
        end else begin
            auto_q <= 1'b0;
            unique case (state_q)
                LDR_IDLE: begin
                    if (start_i || auto_q) begin
                        state_q   <= LDR_SCAN;
                        idx_q     <= '0;
                        done_o    <= 1'b0;
                        err_o     <= 1'b0;
                        err_idx_o <= '0;
                        busy_o    <= 1'b1;
                        verify_q  <= verify_en_i;
                    end
                end
                LDR_SCAN: begin
                    if (last_c) begin
                        state_q <= LDR_DONE;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                    end else if (cur_vld_c) begin
                        state_q <= LDR_WR_REQ;
                        req_o   <= 1'b1;
                        we_o    <= 1'b1;
                        be_o    <= 4'hF;
                        addr_o  <= cur_addr_c;
                        data_o  <= cur_data_c;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                LDR_WR_REQ, LDR_RD_REQ: begin
                    if (gnt_i) begin
                        req_o   <= 1'b0;
                        state_q <= (state_q == LDR_WR_REQ) ? LDR_WR_RSP : LDR_RD_RSP;
                    end
                end
                LDR_WR_RSP: begin
                    if (rvalid_i) begin
                        if (verify_q) begin
                            state_q <= LDR_RD_REQ;
                            req_o   <= 1'b1;
                            we_o    <= 1'b0;
                            be_o    <= 4'hF;
                            addr_o  <= cur_addr_c;
                            data_o  <= '0;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= LDR_SCAN;
                        end
                    end
                end
                LDR_RD_RSP: begin
                    if (rvalid_i) begin
                        if (data_i == cur_data_c) begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= LDR_SCAN;
                        end else begin
                            err_idx_o <= idx_q;
                            err_o     <= 1'b1;
                            busy_o    <= 1'b0;
                            state_q   <= LDR_ERR;
                        end
                    end
                end
                LDR_DONE: state_q <= LDR_IDLE;
                LDR_ERR:  state_q <= LDR_IDLE;
                default:  state_q <= LDR_IDLE;
            endcase

            // A stalled slave aborts the sequence; a same-cycle handshake wins.
            if (in_wait_c && !step_c && tmo_c) begin
                req_o     <= 1'b0;
                err_idx_o <= idx_q;
                err_o     <= 1'b1;
                busy_o    <= 1'b0;
                state_q   <= LDR_ERR;
            end
        end
    end

endmodule

// File: tb/tb_pinmux_cfg_loader.sv
// Scoreboard bench for pinmux_cfg_loader against a zero-wait OBI slave model
// that can stall grants or corrupt one read-back.
module tb_pinmux_cfg_loader;
    import pinmux_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = $clog2(N) + 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic              verify_en_i;
    logic [N-1:0]      cfg_vld_i;
    logic [N-1:0][15:0] cfg_addr_i;
    logic [N-1:0][31:0] cfg_data_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [IW-1:0]     err_idx_o;
    logic              req_o;
    logic              we_o;
    logic [3:0]        be_o;
    logic [31:0]       addr_o;
    logic [31:0]       data_o;
    logic              gnt_i;
    logic              rvalid_i;
    logic [31:0]       data_i;

    logic              gnt_en;
    logic              bad_en;
    logic [31:0]       bad_addr;
    logic [31:0]       last_wdata;

    txn_t exp_q[$];
    int   n_chk   = 0;
    int   n_err   = 0;
    int   txn_cnt = 0;

    always #5 clk_i = ~clk_i;

    pinmux_cfg_loader #(
        .ENTRY_NUM  (N),
        .BASE_ADDR  (32'h0400_0000),
        .TIMEOUT    (64),
        .AUTO_START (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .verify_en_i (verify_en_i),
        .cfg_vld_i   (cfg_vld_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_data_i  (cfg_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_idx_o   (err_idx_o),
        .req_o       (req_o),
        .we_o        (we_o),
        .be_o        (be_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .gnt_i       (gnt_i),
        .rvalid_i    (rvalid_i),
        .data_i      (data_i)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Slave: combinational grant, response one cycle after grant, reads echo the last write.
    assign gnt_i = req_o & gnt_en;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_i   <= 1'b0;
            data_i     <= 32'h0;
            last_wdata <= 32'h0;
        end else begin
            rvalid_i <= req_o && gnt_i;
            if (req_o && gnt_i) begin
                if (we_o) begin
                    last_wdata <= data_o;
                    data_i     <= 32'h0;
                end else begin
                    data_i <= (bad_en && addr_o == bad_addr) ? 32'hDEAD_BEEF : last_wdata;
                end
            end
        end
    end

    // Every granted request is popped from the scoreboard and compared.
    always @(negedge clk_i) begin
        txn_t e;
        if (rst_ni === 1'b1 && req_o && gnt_i) begin
            txn_cnt++;
            chk("bus_be", 32'(be_o), 32'hF);
            if (exp_q.size() == 0) begin
                chk("bus_unexpected_txn", addr_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("bus_we", 32'(we_o), 32'(e.we));
                chk("bus_addr", addr_o, e.addr);
                chk("bus_data", data_o, e.data);
            end
        end
    end

    task automatic load_table(input logic [N-1:0] vld, input logic ver);
        cfg_vld_i   = vld;
        verify_en_i = ver;
        for (int unsigned k = 0; k < N; k++) begin
            cfg_addr_i[k] = pinmux_pad_offset(k);
            cfg_data_i[k] = $urandom;
            if (cfg_data_i[k] == 32'hDEAD_BEEF) cfg_data_i[k] = 32'h1234_5678;
        end
    endtask

    task automatic push_txn(input int unsigned k, input logic wr);
        txn_t t;
        t.we   = wr;
        t.addr = 32'h0400_0000 + 32'(k) * 32'd4;
        t.data = wr ? cfg_data_i[k] : 32'h0;
        exp_q.push_back(t);
    endtask

    // Optionally start, then run until the sequence ends; counts busy cycles.
    task automatic run_seq(input bit do_start, input int extra_at,
                           output int busy_n, output int end_cyc);
        int n;
        bit fin;
        n      = 0;
        fin    = 1'b0;
        busy_n = 0;
        if (do_start) begin
            repeat (2) @(negedge clk_i);
            start_i = 1'b1;
        end
        while (!fin && n < 400) begin
            @(negedge clk_i);
            n++;
            start_i = (n == extra_at);
            if (busy_o) busy_n++;
            if (!busy_o && (done_o || err_o)) fin = 1'b1;
        end
        end_cyc = n - 1;
        if (!fin) chk("run_finished", 32'(fin), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          busy_n;
        int          end_cyc;
        int          t0;
        int          held;
        bit          found;
        bit          stable;
        bit          seen;
        logic [31:0] a0;
        logic [31:0] d0;

        rst_ni   = 1'b0;
        start_i  = 1'b0;
        gnt_en   = 1'b1;
        bad_en   = 1'b0;
        bad_addr = 32'h0;
        load_table('1, 1'b0);
        for (int unsigned k = 0; k < N; k++) push_txn(k, 1'b1);

        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_idx", 32'(err_idx_o), 32'd0);
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_be", 32'(be_o), 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_data", data_o, 32'd0);

        // Auto-start after reset release: 8 plain writes.
        t0 = txn_cnt;
        rst_ni = 1'b1;
        run_seq(1'b0, -1, busy_n, end_cyc);
        chk("auto_done", 32'(done_o), 32'd1);
        chk("auto_err", 32'(err_o), 32'd0);
        chk("auto_done_cycle", 32'(end_cyc), 32'd25);
        chk("auto_busy_cycles", 32'(busy_n), 32'd25);
        chk("auto_writes", 32'(txn_cnt - t0), 32'd8);
        chk("auto_sb_left", 32'(exp_q.size()), 32'd0);

        // Sparse table with verify: entries 0 and 7 only.
        load_table(8'b1000_0001, 1'b1);
        push_txn(0, 1'b1); push_txn(0, 1'b0);
        push_txn(7, 1'b1); push_txn(7, 1'b0);
        t0 = txn_cnt;
        run_seq(1'b1, -1, busy_n, end_cyc);
        chk("sparse_done", 32'(done_o), 32'd1);
        chk("sparse_err", 32'(err_o), 32'd0);
        chk("sparse_busy_cycles", 32'(busy_n), 32'd17);
        chk("sparse_txns", 32'(txn_cnt - t0), 32'd4);
        chk("sparse_sb_left", 32'(exp_q.size()), 32'd0);

        // Verify mismatch on entry 3.
        load_table('1, 1'b1);
        bad_en   = 1'b1;
        bad_addr = 32'h0400_000C;
        for (int unsigned k = 0; k < 4; k++) begin
            push_txn(k, 1'b1);
            push_txn(k, 1'b0);
        end
        t0 = txn_cnt;
        run_seq(1'b1, -1, busy_n, end_cyc);
        chk("vfy_err", 32'(err_o), 32'd1);
        chk("vfy_err_idx", 32'(err_idx_o), 32'd3);
        chk("vfy_done", 32'(done_o), 32'd0);
        chk("vfy_busy_cycles", 32'(busy_n), 32'd20);
        repeat (20) @(negedge clk_i);
        chk("vfy_quiet_bus", 32'(txn_cnt - t0), 32'd8);
        chk("vfy_sb_left", 32'(exp_q.size()), 32'd0);
        bad_en = 1'b0;

        // Grant never arrives: request held for TIMEOUT cycles then abandoned.
        load_table('1, 1'b0);
        gnt_en = 1'b0;
        repeat (2) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 10 && !req_o; i++) @(negedge clk_i);
        a0     = addr_o;
        d0     = data_o;
        held   = 0;
        stable = 1'b1;
        while (req_o && held < 200) begin
            held++;
            if (addr_o != a0 || data_o != d0 || !we_o) stable = 1'b0;
            @(negedge clk_i);
        end
        chk("tmo_req_cycles", 32'(held), 32'd64);
        chk("tmo_stable", 32'(stable), 32'd1);
        chk("tmo_addr", a0, 32'h0400_0000);
        chk("tmo_data", d0, cfg_data_i[0]);
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_err_idx", 32'(err_idx_o), 32'd0);
        chk("tmo_done", 32'(done_o), 32'd0);
        chk("tmo_busy", 32'(busy_o), 32'd0);
        gnt_en = 1'b1;

        // Start pulses while busy and on the DONE cycle are ignored.
        load_table('1, 1'b0);
        for (int unsigned k = 0; k < N; k++) push_txn(k, 1'b1);
        t0 = txn_cnt;
        run_seq(1'b1, 6, busy_n, end_cyc);
        chk("busy_start_done", 32'(done_o), 32'd1);
        chk("busy_start_cycles", 32'(busy_n), 32'd25);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk_i);
            if (busy_o) seen = 1'b1;
        end
        chk("busy_start_no_rerun", 32'(seen), 32'd0);
        chk("busy_start_writes", 32'(txn_cnt - t0), 32'd8);
        chk("busy_start_done_sticky", 32'(done_o), 32'd1);
        chk("busy_start_sb_left", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for the write response of entry 4.
        load_table('1, 1'b0);
        for (int unsigned k = 0; k < N; k++) push_txn(k, 1'b1);
        t0 = txn_cnt;
        repeat (2) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (req_o && gnt_i && addr_o == 32'h0400_0010) found = 1'b1;
            else @(negedge clk_i);
        end
        chk("rstmid_reached", 32'(found), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rstmid_req", 32'(req_o), 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        chk("rstmid_partial", 32'(txn_cnt - t0), 32'd5);
        exp_q.delete();
        for (int unsigned k = 0; k < N; k++) push_txn(k, 1'b1);
        repeat (2) @(negedge clk_i);
        t0 = txn_cnt;
        rst_ni = 1'b1;
        run_seq(1'b0, -1, busy_n, end_cyc);
        chk("rstmid_done", 32'(done_o), 32'd1);
        chk("rstmid_busy_cycles", 32'(busy_n), 32'd25);
        chk("rstmid_writes", 32'(txn_cnt - t0), 32'd8);
        chk("rstmid_sb_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
